// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Two-master / one-slave data-bus arbiter with round-robin choice
//            between simultaneous requesters, a registered slave bus, a
//            one-cycle ready/error return pulse and an abort watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,          // active-low, asynchronous
  // master 0 (core load/store port)
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  input  logic                  m0_write,
  input  logic                  m0_read,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  output logic                  m0_ready,
  output logic                  m0_error,
  // master 1 (secondary requester)
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  input  logic                  m1_write,
  input  logic                  m1_read,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  m1_ready,
  output logic                  m1_error,
  // slave bus
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [DATA_WIDTH-1:0] s_write_data,
  output logic                  s_write,
  output logic                  s_read,
  input  logic [DATA_WIDTH-1:0] s_read_data,
  input  logic                  s_ready,
  output logic [1:0]            grant
);

  // Watchdog counter is at least 8 bits and wide enough to reach TIMEOUT-1.
  localparam int c_CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST =
      (TIMEOUT == 0) ? '0 : c_CNT_W'(TIMEOUT - 1);
  localparam bit c_WDOG_EN = (TIMEOUT != 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;     // 0 = m0 won last, 1 = m1 won last
  logic [c_CNT_W-1:0]    r_cnt;
  logic [ADDR_WIDTH-1:0] r_s_address;
  logic [DATA_WIDTH-1:0] r_s_write_data;
  logic                  r_s_write;
  logic                  r_s_read;
  logic [1:0]            r_grant;
  logic                  r_m0_ready, r_m0_error;
  logic                  r_m1_ready, r_m1_error;
  logic [DATA_WIDTH-1:0] r_m0_read_data, r_m1_read_data;

  logic w_req0, w_req1;
  logic w_start;     // grant edge in IDLE
  logic w_winner;    // 0 = m0, 1 = m1
  logic w_done;      // slave completed the access
  logic w_abort;     // watchdog expired

  // A master that is seeing its ready pulse cannot request again this cycle,
  // so a request still held while the master reacts is not re-issued.
  assign w_req0 = (m0_read | m0_write) & ~r_m0_ready;
  assign w_req1 = (m1_read | m1_write) & ~r_m1_ready;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and control decode: arbitration in IDLE, completion/abort in BUSY.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_winner     = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          w_start      = 1'b1;
          // Round-robin on a tie: the master that did not win last time.
          w_winner     = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (s_ready) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end else if (c_WDOG_EN && (r_cnt == c_CNT_LAST)) begin
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Slave-bus registers, owner tracking, watchdog and master return pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_grant   <= 1'b1;   // favours m0 on the first tie
      r_cnt          <= '0;
      r_s_address    <= '0;
      r_s_write_data <= '0;
      r_s_write      <= 1'b0;
      r_s_read       <= 1'b0;
      r_grant        <= 2'b00;
      r_m0_ready     <= 1'b0;
      r_m0_error     <= 1'b0;
      r_m0_read_data <= '0;
      r_m1_ready     <= 1'b0;
      r_m1_error     <= 1'b0;
      r_m1_read_data <= '0;
    end else begin
      // Return signals are single-cycle; cleared unless set below.
      r_m0_ready     <= 1'b0;
      r_m0_error     <= 1'b0;
      r_m0_read_data <= '0;
      r_m1_ready     <= 1'b0;
      r_m1_error     <= 1'b0;
      r_m1_read_data <= '0;

      if (w_start) begin
        // Write wins when a master raises both strobes.
        if (w_winner) begin
          r_s_address    <= m1_address;
          r_s_write_data <= m1_write_data;
          r_s_write      <= m1_write;
          r_s_read       <= m1_read & ~m1_write;
          r_grant        <= 2'b10;
        end else begin
          r_s_address    <= m0_address;
          r_s_write_data <= m0_write_data;
          r_s_write      <= m0_write;
          r_s_read       <= m0_read & ~m0_write;
          r_grant        <= 2'b01;
        end
        r_last_grant <= w_winner;
        r_cnt        <= '0;
      end else if (w_done || w_abort) begin
        r_s_write <= 1'b0;
        r_s_read  <= 1'b0;
        r_grant   <= 2'b00;
        if (r_grant[1]) begin
          r_m1_ready     <= 1'b1;
          r_m1_error     <= w_abort;
          r_m1_read_data <= (w_done && r_s_read) ? s_read_data : '0;
        end else begin
          r_m0_ready     <= 1'b1;
          r_m0_error     <= w_abort;
          r_m0_read_data <= (w_done && r_s_read) ? s_read_data : '0;
        end
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign s_address     = r_s_address;
  assign s_write_data  = r_s_write_data;
  assign s_write       = r_s_write;
  assign s_read        = r_s_read;
  assign grant         = r_grant;
  assign m0_ready      = r_m0_ready;
  assign m0_error      = r_m0_error;
  assign m0_read_data  = r_m0_read_data;
  assign m1_ready      = r_m1_ready;
  assign m1_error      = r_m1_error;
  assign m1_read_data  = r_m1_read_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed self-checking bench for bus_arbiter. Instance dut uses
//            the default watchdog; instance dut4 (TIMEOUT=4) shares the same
//            stimulus and is checked only in the watchdog scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic        m0_write, m0_read, m1_write, m1_read;
  logic [31:0] s_read_data;
  logic        s_ready;

  logic [31:0] m0_read_data, m1_read_data, s_address, s_write_data;
  logic        m0_ready, m0_error, m1_ready, m1_error, s_write, s_read;
  logic [1:0]  grant;

  logic [31:0] t4_m0_read_data, t4_m1_read_data, t4_s_address, t4_s_write_data;
  logic        t4_m0_ready, t4_m0_error, t4_m1_ready, t4_m1_error;
  logic        t4_s_write, t4_s_read;
  logic [1:0]  t4_grant;

  int checks = 0;
  int errors = 0;

  bus_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_write_data(m0_write_data),
    .m0_write(m0_write), .m0_read(m0_read),
    .m0_read_data(m0_read_data), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_address(m1_address), .m1_write_data(m1_write_data),
    .m1_write(m1_write), .m1_read(m1_read),
    .m1_read_data(m1_read_data), .m1_ready(m1_ready), .m1_error(m1_error),
    .s_address(s_address), .s_write_data(s_write_data),
    .s_write(s_write), .s_read(s_read),
    .s_read_data(s_read_data), .s_ready(s_ready), .grant(grant)
  );

  bus_arbiter #(.TIMEOUT(4)) dut4 (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_write_data(m0_write_data),
    .m0_write(m0_write), .m0_read(m0_read),
    .m0_read_data(t4_m0_read_data), .m0_ready(t4_m0_ready), .m0_error(t4_m0_error),
    .m1_address(m1_address), .m1_write_data(m1_write_data),
    .m1_write(m1_write), .m1_read(m1_read),
    .m1_read_data(t4_m1_read_data), .m1_ready(t4_m1_ready), .m1_error(t4_m1_error),
    .s_address(t4_s_address), .s_write_data(t4_s_write_data),
    .s_write(t4_s_write), .s_read(t4_s_read),
    .s_read_data(s_read_data), .s_ready(s_ready), .grant(t4_grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge (start of next cycle).
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_write_data = '0; m0_write = 1'b0; m0_read = 1'b0;
    m1_address = '0; m1_write_data = '0; m1_write = 1'b0; m1_read = 1'b0;
    s_read_data = '0; s_ready = 1'b0;
  endtask

  // Leaves the bench in cycle 0 with reset just released.
  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    step();
    step();
    checks++;
    if ({s_read, s_write, grant, m0_ready, m0_error, m1_ready, m1_error} !== 8'h00 ||
        s_address !== 32'h0 || s_write_data !== 32'h0 ||
        m0_read_data !== 32'h0 || m1_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b addr=%h wd=%h rd0=%h rd1=%h required all zero",
               {s_read, s_write, grant, m0_ready, m0_error, m1_ready, m1_error},
               s_address, s_write_data, m0_read_data, m1_read_data);
    end
    reset = 1'b1;
  endtask

  // Single read with zero wait states; request held through the ready cycle.
  task automatic test_single_read();
    apply_reset();
    m0_read = 1'b1; m0_address = 32'h100;
    step();                                     // cycle 1
    checks++;
    if ({s_read, s_write, grant} !== 4'b1001 || s_address !== 32'h100) begin
      errors++;
      $display("FAIL read_strobe: rd/wr/grant=%b addr=%h required 1001 addr=00000100",
               {s_read, s_write, grant}, s_address);
    end
    s_ready = 1'b1; s_read_data = 32'hDEADBEEF;
    step();                                     // cycle 2
    checks++;
    if ({m0_ready, m0_error, grant, s_read} !== 5'b10000 || m0_read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_ready: rdy/err/grant/s_read=%b data=%h required 10000 data=deadbeef",
               {m0_ready, m0_error, grant, s_read}, m0_read_data);
    end
    s_ready = 1'b0; s_read_data = 32'h0;        // m0_read still held this cycle
    step();                                     // cycle 3
    m0_read = 1'b0;
    checks++;
    if ({m0_ready, s_read, grant} !== 4'b0000 || m0_read_data !== 32'h0) begin
      errors++;
      $display("FAIL read_no_reissue: rdy/s_read/grant=%b data=%h required 0000 data=0",
               {m0_ready, s_read, grant}, m0_read_data);
    end
  endtask

  // Both masters write continuously; slave always ready.
  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    apply_reset();
    m0_write = 1'b1; m0_address = 32'hA000; m0_write_data = 32'h11110000;
    m1_write = 1'b1; m1_address = 32'hB000; m1_write_data = 32'h22220000;
    s_ready  = 1'b1;
    for (int t = 0; t < 6; t++) begin
      exp_addr = (t % 2 == 0) ? 32'hA000 : 32'hB000;
      exp_data = (t % 2 == 0) ? 32'h11110000 : 32'h22220000;
      step();
      checks++;
      if (s_address !== exp_addr || s_write_data !== exp_data || s_write !== 1'b1 ||
          grant !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: addr=%h data=%h wr=%b grant=%b required addr=%h data=%h wr=1",
                 t, s_address, s_write_data, s_write, grant, exp_addr, exp_data);
      end
      step();
      checks++;
      if ({m0_ready, m1_ready} !== ((t % 2 == 0) ? 2'b10 : 2'b01) ||
          s_write !== 1'b0 || grant !== 2'b00) begin
        errors++;
        $display("FAIL rr_ready[%0d]: m0/m1 ready=%b s_write=%b grant=%b required %b s_write=0 grant=00",
                 t, {m0_ready, m1_ready}, s_write, grant, (t % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    clear_inputs();
  endtask

  // m1 write with 5 wait cycles; m0 read arrives mid-transfer.
  task automatic test_wait_states();
    apply_reset();
    m1_write = 1'b1; m1_address = 32'h40; m1_write_data = 32'h55AA;
    for (int c = 1; c <= 6; c++) begin
      step();                                   // cycles 1..6
      if (c == 2) begin m0_read = 1'b1; m0_address = 32'h200; end
      if (c == 6) s_ready = 1'b1;
      checks++;
      if (s_address !== 32'h40 || s_write_data !== 32'h55AA ||
          {s_write, s_read, grant, m0_ready, m1_ready} !== 6'b101000) begin
        errors++;
        $display("FAIL wait_stable[%0d]: addr=%h data=%h wr/rd/grant/r0/r1=%b required 40 55aa 101000",
                 c, s_address, s_write_data, {s_write, s_read, grant, m0_ready, m1_ready});
      end
    end
    step();                                     // cycle 7
    s_ready = 1'b0; m1_write = 1'b0;
    checks++;
    if ({m1_ready, m1_error, m0_ready, grant} !== 5'b10000 || m1_read_data !== 32'h0) begin
      errors++;
      $display("FAIL wait_ready: r1/e1/r0/grant=%b rd1=%h required 10000 rd1=0",
               {m1_ready, m1_error, m0_ready, grant}, m1_read_data);
    end
    step();                                     // cycle 8: m0 granted in cycle 7
    checks++;
    if ({s_read, s_write, grant} !== 4'b1001 || s_address !== 32'h200) begin
      errors++;
      $display("FAIL wait_next_grant: rd/wr/grant=%b addr=%h required 1001 addr=200",
               {s_read, s_write, grant}, s_address);
    end
    clear_inputs();
  endtask

  // Watchdog abort with TIMEOUT=4 on dut4; default-timeout dut stays busy.
  task automatic test_timeout();
    apply_reset();
    m0_read = 1'b1; m0_address = 32'h300;
    s_read_data = 32'hFFFFFFFF;                 // must not leak to the master
    step();                                     // cycle 1: strobe
    checks++;
    if (t4_s_read !== 1'b1) begin
      errors++;
      $display("FAIL tmo_strobe: s_read=%b required 1", t4_s_read);
    end
    for (int c = 2; c <= 4; c++) begin
      step();
      checks++;
      if ({t4_m0_ready, t4_s_read} !== 2'b01) begin
        errors++;
        $display("FAIL tmo_wait[%0d]: ready/s_read=%b required 01", c, {t4_m0_ready, t4_s_read});
      end
    end
    step();                                     // cycle 5
    checks++;
    if ({t4_m0_ready, t4_m0_error, t4_s_read, t4_grant} !== 5'b11000 ||
        t4_m0_read_data !== 32'h0) begin
      errors++;
      $display("FAIL tmo_abort: ready/err/s_read/grant=%b data=%h required 11000 data=0",
               {t4_m0_ready, t4_m0_error, t4_s_read, t4_grant}, t4_m0_read_data);
    end
    checks++;
    if ({m0_ready, s_read, grant} !== 4'b0101) begin
      errors++;
      $display("FAIL tmo_default_busy: ready/s_read/grant=%b required 0101",
               {m0_ready, s_read, grant});
    end
    step();                                     // cycle 6: masked, back in IDLE
    m0_read = 1'b0;
    checks++;
    if ({t4_m0_ready, t4_m0_error, t4_s_read, t4_grant} !== 5'b00000) begin
      errors++;
      $display("FAIL tmo_idle: ready/err/s_read/grant=%b required 00000",
               {t4_m0_ready, t4_m0_error, t4_s_read, t4_grant});
    end
    clear_inputs();
  endtask

  // Asynchronous reset during the 3rd wait cycle of an m1 read.
  task automatic test_reset_mid_access();
    apply_reset();
    m1_read = 1'b1; m1_address = 32'h80;
    step(); step(); step();                     // cycle 3
    checks++;
    if ({s_read, grant} !== 3'b110) begin
      errors++;
      $display("FAIL midrst_busy: s_read/grant=%b required 110", {s_read, grant});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({s_read, s_write, grant, m1_ready, m0_ready} !== 6'b000000) begin
      errors++;
      $display("FAIL midrst_async: rd/wr/grant/r1/r0=%b required 000000",
               {s_read, s_write, grant, m1_ready, m0_ready});
    end
    m0_read = 1'b1; m0_address = 32'h90;
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({s_read, grant, m1_ready} !== 4'b1010 || s_address !== 32'h90) begin
      errors++;
      $display("FAIL midrst_favour_m0: s_read/grant/r1=%b addr=%h required 1010 addr=90",
               {s_read, grant, m1_ready}, s_address);
    end
    clear_inputs();
  endtask

  // Read+write together is a write; also s_ready while IDLE is ignored.
  task automatic test_read_write_both();
    apply_reset();
    s_ready = 1'b1; s_read_data = 32'hCAFE;
    step();
    checks++;
    if ({m0_ready, m1_ready, s_read, s_write, grant} !== 6'b000000) begin
      errors++;
      $display("FAIL idle_ready_ignored: r0/r1/rd/wr/grant=%b required 000000",
               {m0_ready, m1_ready, s_read, s_write, grant});
    end
    s_ready = 1'b0;
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 32'h44; m0_write_data = 32'h1234;
    step();
    checks++;
    if ({s_write, s_read} !== 2'b10 || s_write_data !== 32'h1234 || s_address !== 32'h44) begin
      errors++;
      $display("FAIL rw_is_write: wr/rd=%b data=%h addr=%h required 10 data=1234 addr=44",
               {s_write, s_read}, s_write_data, s_address);
    end
    s_ready = 1'b1;
    step();
    checks++;
    if ({m0_ready, m0_error} !== 2'b10 || m0_read_data !== 32'h0) begin
      errors++;
      $display("FAIL rw_ready: rdy/err=%b data=%h required 10 data=0",
               {m0_ready, m0_error}, m0_read_data);
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_reset_mid_access();
    test_read_write_both();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the core's data bus.
- Master 0 is the riscv_core load/store port; master 1 is a secondary requester (DMA or debug loader).
- Registers the winning request onto a single slave bus and returns a one-cycle ready/error pulse to the owner.
- Watchdog aborts a hung slave access.
- Core integration gates pc advance on m0_ready for bus instructions.

Parameters:
ADDR_WIDTH, 32, address width of all address ports
DATA_WIDTH, 32, data width of all data ports
TIMEOUT, 255, max BUSY cycles waiting for s_ready before abort; 0 disables the watchdog; 8-bit counter minimum, sized to hold TIMEOUT

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
m0_address  in  ADDR_WIDTH  master 0 address
m0_write_data  in  DATA_WIDTH  master 0 store data
m0_write  in  1  master 0 write request
m0_read  in  1  master 0 read request
m0_read_data  out  DATA_WIDTH  master 0 load data, valid while m0_ready=1
m0_ready  out  1  one-cycle completion pulse to master 0
m0_error  out  1  qualifies m0_ready: access aborted by timeout
m1_address, m1_write_data, m1_write, m1_read, m1_read_data, m1_ready, m1_error  same widths and meaning for master 1
s_address  out  ADDR_WIDTH  slave address (registered)
s_write_data  out  DATA_WIDTH  slave store data (registered)
s_write  out  1  slave write strobe (registered)
s_read  out  1  slave read strobe (registered)
s_read_data  in  DATA_WIDTH  slave load data, sampled when s_ready=1
s_ready  in  1  slave completion
grant  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle

Behaviour:
- Reset (reset=0, async):
  - State IDLE; last_grant=1, so m0 is favoured first.
  - All outputs 0; watchdog counter 0.
  - Reset mid-transaction drops s_read/s_write immediately; no ready pulse is ever issued for the aborted access.
- Request definition: req_n = mN_read | mN_write. If both read and write are high, the access is a write; read is ignored.
- Mask rule: a master whose mN_ready is high this cycle is not a requester this cycle. This prevents a held request from re-issuing.
- States: IDLE, BUSY.
- IDLE:
  - No unmasked request: stay IDLE.
  - Exactly one unmasked request: grant it.
  - Both requesting: grant the master that is not last_grant (round-robin).
  - On the grant edge: latch address, write data and direction into the s_* registers; set grant; last_grant <= winner; counter <= 0; go BUSY.
- BUSY:
  - s_* outputs are held constant.
  - s_ready=1: for the owner, mN_ready=1 next cycle, mN_error=0, mN_read_data <= s_read_data on a read (0 on a write). s_read/s_write <= 0, grant <= 00, go IDLE.
  - s_ready=0 and TIMEOUT!=0 and counter==TIMEOUT-1: owner gets mN_ready=1, mN_error=1, read data 0. Strobes drop, go IDLE.
  - Otherwise counter increments.
- Latency:
  - Request seen in cycle 0 gives s_* asserted in cycle 1.
  - With s_ready in cycle k≥1, mN_ready is asserted in cycle k+1.
  - Minimum round trip is 2 cycles.
  - The earliest next grant is issued in that same k+1 cycle (IDLE), with strobes asserted in k+2.
- mN_ready, mN_error and mN_read_data are pulses/valid for exactly one cycle; otherwise 0.
- Masters must hold address, data and strobes until their ready. Changes before grant are followed; changes after grant are ignored.
- s_ready while IDLE is ignored.
- No starvation: with both masters requesting continuously, grants alternate m0, m1, m0, ...

Test Plan:
- Reset release, m0_read at 0x100, slave returns 0xDEADBEEF with 0 wait → s_read high in cycle 1, m0_ready=1 with m0_read_data=0xDEADBEEF in cycle 2, grant 01 then 00.
- m0 and m1 both write continuously, slave ready every cycle → s_address alternates m0/m1 addresses, m0 first; each master gets one ready per 2 transactions; no duplicate write from the held request.
- m1_write 0x55AA to 0x40 with s_ready delayed 5 cycles; m0_read arrives mid-transfer → s_* stable for all 5 cycles; m1_ready in cycle 7; m0 granted in cycle 7.
- TIMEOUT=4, slave never ready, m0_read → m0_ready=1, m0_error=1, m0_read_data=0 exactly 4 cycles after strobe assertion; returns to IDLE.
- Assert reset=0 during the 3rd wait cycle of a BUSY access → strobes, grant, ready 0 immediately; after release, m0 favoured on a simultaneous request.
- m0_read and m0_write both high with data 0x1234 → s_write=1, s_read=0, m0_read_data=0 on ready.
